// File: rtl/rs_issue_sched_if.sv
// rs_sched_if: handshake bundle between the RS array and its issue/alloc scheduler
// Inputs to the scheduler:
//   pipe_flush     squash; no grants or allocations this cycle
//   dispatch_valid per dispatch slot: slot carries an instruction
//   rs_avail       per entry: entry is free
//   rs_wake_up     [entry][port]: entry ready for issue on that port
//   rs_age         [entry]: ROB tag of the entry (includes wrap bit)
//   rob_head       ROB head tag
//   fu_ready       per port: functional unit accepts an issue this cycle
// Outputs from the scheduler:
//   alloc_sel      [entry][slot] one-hot: dispatch slot -> free entry
//   dispatch_stall not enough free entries for all valid dispatch slots
//   issue_sel      [port][entry] one-hot grant per port
//   rs_use_en      per entry: OR of all issue_sel rows
//   issue_valid    per port: port granted this cycle
// master = RS array side, slave = scheduler side.
interface rs_sched_if #(
    parameter int RS_DEPTH      = 16,
    parameter int ISSUE_WIDTH   = 2,
    parameter int MACHINE_WIDTH = 2,
    parameter int AGE_W         = 6
);
    logic                                      pipe_flush;
    logic [MACHINE_WIDTH-1:0]                  dispatch_valid;
    logic [RS_DEPTH-1:0]                       rs_avail;
    logic [RS_DEPTH-1:0][ISSUE_WIDTH-1:0]      rs_wake_up;
    logic [RS_DEPTH-1:0][AGE_W-1:0]            rs_age;
    logic [AGE_W-1:0]                          rob_head;
    logic [ISSUE_WIDTH-1:0]                    fu_ready;
    logic [RS_DEPTH-1:0][MACHINE_WIDTH-1:0]    alloc_sel;
    logic                                      dispatch_stall;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]      issue_sel;
    logic [RS_DEPTH-1:0]                       rs_use_en;
    logic [ISSUE_WIDTH-1:0]                    issue_valid;

    modport master (
        output pipe_flush, dispatch_valid, rs_avail, rs_wake_up, rs_age, rob_head, fu_ready,
        input  alloc_sel, dispatch_stall, issue_sel, rs_use_en, issue_valid
    );

    modport slave (
        input  pipe_flush, dispatch_valid, rs_avail, rs_wake_up, rs_age, rob_head, fu_ready,
        output alloc_sel, dispatch_stall, issue_sel, rs_use_en, issue_valid
    );
endinterface

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: dispatch allocation and oldest-first issue scheduler for one RS array
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset; all outputs forced to 0 while high
//   bus            rs_sched_if.slave (flush, dispatch/avail/wake/age inputs; alloc/issue selects out)
//   perf_issue_cnt (RS_SCHED_PERF_EN only) running count of issued instructions, wraps at 2^32
//   perf_stall_cnt (RS_SCHED_PERF_EN only) running count of dispatch-stall cycles, wraps at 2^32
// Optional feature macro: RS_SCHED_PERF_EN adds the two performance counters; without it the
// ports are absent and scheduling behaviour is unchanged.
// Issue: ports resolve in order; each port grants its oldest eligible entry (ROB-relative age,
// lower index on ties), except that after STARVE_LIMIT contended age grants it makes one
// round-robin grant starting at its rr pointer so young entries cannot starve forever.
// Allocation: valid dispatch slots take the lowest free entries in order, all-or-nothing.
module rs_issue_sched #(
    parameter int RS_DEPTH      = 16,
    parameter int ISSUE_WIDTH   = 2,
    parameter int MACHINE_WIDTH = 2,
    parameter int AGE_W         = 6,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    rs_sched_if.slave   bus
`ifdef RS_SCHED_PERF_EN
    ,
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int PW = $clog2(RS_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [RS_DEPTH-1:0]                    granted_q;
    logic [ISSUE_WIDTH-1:0][PW-1:0]         rr_ptr, rr_ptr_nxt;
    logic [ISSUE_WIDTH-1:0][CW-1:0]         starve_cnt, starve_cnt_nxt;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]   sel;
    logic [RS_DEPTH-1:0]                    req, use_en;
    logic [AGE_W-1:0]                       rel, best_rel;
    logic                                   found, active, stall, hit;
    int                                     n_req, best, idx;
    logic [MACHINE_WIDTH-1:0]               slots_left;
    logic [RS_DEPTH-1:0][MACHINE_WIDTH-1:0] alloc;

    // Flush and reset both suppress every grant and allocation combinationally.
    assign active = ~rst & ~bus.pipe_flush;

    // use_en accumulates grants of earlier ports so later ports skip them; its final
    // value is the OR of all port grants.
    always_comb begin
        sel            = '0;
        use_en         = '0;
        rr_ptr_nxt     = rr_ptr;
        starve_cnt_nxt = starve_cnt;
        req            = '0;
        rel            = '0;
        best_rel       = '0;
        found          = 1'b0;
        n_req          = 0;
        best           = 0;
        idx            = 0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int e = 0; e < RS_DEPTH; e++)
                req[e] = bus.rs_wake_up[e][p] & ~granted_q[e] & ~use_en[e] & bus.fu_ready[p] & active;
            n_req    = $countones(req);
            found    = 1'b0;
            best     = 0;
            best_rel = '0;
            if (n_req != 0 && int'(starve_cnt[p]) == STARVE_LIMIT) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    idx = (int'(rr_ptr[p]) + i) % RS_DEPTH;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        best  = idx;
                    end
                end
                rr_ptr_nxt[p]     = PW'((best + 1) % RS_DEPTH);
                starve_cnt_nxt[p] = '0;
            end else if (n_req != 0) begin
                // Strict compare while scanning upward keeps the lower index on equal age.
                for (int e = 0; e < RS_DEPTH; e++) begin
                    rel = bus.rs_age[e] - bus.rob_head;
                    if (req[e] && (!found || rel < best_rel)) begin
                        found    = 1'b1;
                        best     = e;
                        best_rel = rel;
                    end
                end
                // Below the limit here, so the increment cannot pass saturation.
                starve_cnt_nxt[p] = n_req == 1 ? '0 : starve_cnt[p] + 1'b1;
            end
            if (found)
                sel[p][best] = 1'b1;
            use_en = use_en | sel[p];
        end
    end

    always_comb begin
        stall      = active && ($countones(bus.rs_avail) < $countones(bus.dispatch_valid));
        alloc      = '0;
        slots_left = bus.dispatch_valid;
        hit        = 1'b0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            hit = 1'b0;
            for (int k = 0; k < MACHINE_WIDTH; k++) begin
                if (bus.rs_avail[e] && slots_left[k] && !hit) begin
                    alloc[e][k]   = 1'b1;
                    slots_left[k] = 1'b0;
                    hit           = 1'b1;
                end
            end
        end
        alloc = (!active || stall) ? '0 : alloc;
    end

    assign bus.issue_sel      = sel;
    assign bus.rs_use_en      = use_en;
    assign bus.alloc_sel      = alloc;
    assign bus.dispatch_stall = stall;

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_valid
        assign bus.issue_valid[g] = |sel[g];
    end

    // granted_q masks a just-issued entry for one cycle while the RS array clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            granted_q  <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else if (bus.pipe_flush) begin
            granted_q  <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            granted_q  <= use_en;
            rr_ptr     <= rr_ptr_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

`ifdef RS_SCHED_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'($countones(bus.issue_valid));
            perf_stall_cnt <= perf_stall_cnt + {31'b0, bus.dispatch_stall};
        end
    end
`endif
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched: randomized bench for rs_issue_sched against a queue-based reference model
module tb_rs_issue_sched;
    localparam int D  = 16;
    localparam int IW = 2;
    localparam int MW = 2;
    localparam int AW = 6;
    localparam int SL = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_ptr [IW];
    int   m_cnt [IW];
    bit [D-1:0] m_gq;
    int   exp_seq [10] = '{3, 2, 3, 2, 3, 2, 3, 2, 0, 3};

    rs_sched_if #(.RS_DEPTH(D), .ISSUE_WIDTH(IW), .MACHINE_WIDTH(MW), .AGE_W(AW)) bus ();

`ifdef RS_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
    longint      m_issue = 0, m_stall = 0;
`endif

    rs_issue_sched #(
        .RS_DEPTH(D), .ISSUE_WIDTH(IW), .MACHINE_WIDTH(MW), .AGE_W(AW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef RS_SCHED_PERF_EN
        ,
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: evaluated on the falling edge, after inputs have settled and before
    // the next rising edge commits the DUT state.
    always @(negedge clk) begin : compare
        logic [IW-1:0][D-1:0] e_sel;
        logic [D-1:0]         e_use;
        logic [IW-1:0]        e_val;
        logic [D-1:0][MW-1:0] e_alloc;
        logic                 e_stall;
        int q[$];
        int fr[$];
        int sl[$];
        int g, key, bk, c;
        e_sel   = '0;
        e_use   = '0;
        e_val   = '0;
        e_alloc = '0;
        e_stall = 1'b0;
        if (rst) begin
            m_gq = '0;
            for (int p = 0; p < IW; p++) begin
                m_ptr[p] = 0;
                m_cnt[p] = 0;
            end
        end else begin
            for (int p = 0; p < IW; p++) begin
                q.delete();
                for (int e = 0; e < D; e++)
                    if (bus.rs_wake_up[e][p] && !m_gq[e] && !e_use[e] && bus.fu_ready[p] && !bus.pipe_flush)
                        q.push_back(e);
                if (q.size() > 0) begin
                    g = -1;
                    if (m_cnt[p] == SL) begin
                        for (int i = 0; i < D; i++) begin
                            c = (m_ptr[p] + i) % D;
                            foreach (q[j]) if (q[j] == c && g < 0) g = c;
                        end
                        m_ptr[p] = (g + 1) % D;
                        m_cnt[p] = 0;
                    end else begin
                        bk = 1 << 30;
                        foreach (q[j]) begin
                            key = ((int'(bus.rs_age[q[j]]) - int'(bus.rob_head) + 64) % 64) * D + q[j];
                            if (key < bk) begin
                                bk = key;
                                g  = q[j];
                            end
                        end
                        m_cnt[p] = q.size() == 1 ? 0 : (m_cnt[p] + 1 > SL ? SL : m_cnt[p] + 1);
                    end
                    e_sel[p][g] = 1'b1;
                    e_use[g]    = 1'b1;
                    e_val[p]    = 1'b1;
                end
            end
            if (!bus.pipe_flush) begin
                fr.delete();
                sl.delete();
                for (int e = 0; e < D; e++) if (bus.rs_avail[e]) fr.push_back(e);
                for (int k = 0; k < MW; k++) if (bus.dispatch_valid[k]) sl.push_back(k);
                e_stall = fr.size() < sl.size();
                if (!e_stall)
                    foreach (sl[j]) e_alloc[fr[j]][sl[j]] = 1'b1;
            end
            m_gq = bus.pipe_flush ? '0 : e_use;
            if (bus.pipe_flush)
                for (int p = 0; p < IW; p++) begin
                    m_ptr[p] = 0;
                    m_cnt[p] = 0;
                end
        end
        chk("issue_sel", 64'(bus.issue_sel), 64'(e_sel));
        chk("rs_use_en", 64'(bus.rs_use_en), 64'(e_use));
        chk("issue_valid", 64'(bus.issue_valid), 64'(e_val));
        chk("alloc_sel", 64'(bus.alloc_sel), 64'(e_alloc));
        chk("dispatch_stall", 64'(bus.dispatch_stall), 64'(e_stall));
`ifdef RS_SCHED_PERF_EN
        if (rst) begin
            m_issue = 0;
            m_stall = 0;
        end
        chk("perf_issue_cnt", 64'(perf_issue_cnt), 64'(m_issue[31:0]));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall[31:0]));
        if (!rst) begin
            m_issue += $countones(e_val);
            m_stall += e_stall;
        end
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_flush     = 1'b0;
        bus.dispatch_valid = '0;
        bus.rs_avail       = '0;
        bus.rs_wake_up     = '0;
        bus.rs_age         = '0;
        bus.rob_head       = '0;
        bus.fu_ready       = '1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.rs_wake_up = '1;
        step();
        step();
        #2;
        chk("reset issue_sel", 64'(bus.issue_sel), 64'h0);
        chk("reset rs_use_en", 64'(bus.rs_use_en), 64'h0);
        chk("reset alloc_sel", 64'(bus.alloc_sel), 64'h0);

        step();
        rst = 1'b0;
        idle();

        step();
        bus.rob_head      = 6'd60;
        bus.rs_age[3]     = 6'd62;
        bus.rs_age[5]     = 6'd1;
        bus.rs_wake_up[3] = 2'b01;
        bus.rs_wake_up[5] = 2'b01;
        bus.fu_ready      = 2'b01;
        #2;
        chk("age wrap first", 64'(bus.issue_sel[0]), 64'h0008);
        step();
        #2;
        chk("age wrap masked", 64'(bus.issue_sel[0]), 64'h0020);

        step();
        idle();
        step();
        bus.rs_age[2]     = 6'd1;
        bus.rs_age[7]     = 6'd5;
        bus.rs_wake_up[2] = 2'b11;
        bus.rs_wake_up[7] = 2'b10;
        #2;
        chk("dual port0", 64'(bus.issue_sel[0]), 64'h0004);
        chk("dual port1", 64'(bus.issue_sel[1]), 64'h0080);
        chk("dual use_en", 64'(bus.rs_use_en), 64'h0084);

        step();
        idle();
        step();
        bus.fu_ready      = 2'b01;
        bus.rs_wake_up[4] = 2'b11;
        bus.rs_wake_up[9] = 2'b11;
        #2;
        chk("backpressure valid", 64'(bus.issue_valid), 64'h1);
        step();
        bus.pipe_flush     = 1'b1;
        bus.dispatch_valid = 2'b11;
        #2;
        chk("flush issue_sel", 64'(bus.issue_sel), 64'h0);
        chk("flush alloc_sel", 64'(bus.alloc_sel), 64'h0);
        chk("flush stall", 64'(bus.dispatch_stall), 64'h0);
        step();
        bus.pipe_flush     = 1'b0;
        bus.dispatch_valid = '0;
        #2;
        chk("post flush grant", 64'(bus.issue_sel[0]), 64'h0010);

        step();
        idle();
        bus.rs_avail       = 16'h0012;
        bus.dispatch_valid = 2'b11;
        #2;
        chk("alloc map", 64'(bus.alloc_sel), 64'h0204);
        chk("alloc no stall", 64'(bus.dispatch_stall), 64'h0);
        step();
        bus.rs_avail = 16'h0010;
        #2;
        chk("alloc stall", 64'(bus.dispatch_stall), 64'h1);
        chk("alloc stall sel", 64'(bus.alloc_sel), 64'h0);

        step();
        idle();
        bus.pipe_flush = 1'b1;
        step();
        bus.pipe_flush = 1'b0;
        bus.fu_ready   = 2'b01;
        for (int e = 0; e < 4; e++) begin
            bus.rs_wake_up[e] = 2'b01;
            bus.rs_age[e]     = 6'(3 - e);
        end
        for (int i = 0; i < 10; i++) begin
            #2;
            chk($sformatf("starve seq %0d", i), 64'(bus.issue_sel[0]), 64'(16'd1 << exp_seq[i]));
            step();
        end

        bus.rs_wake_up = '1;
        rst = 1'b1;
        #2;
        chk("async reset sel", 64'(bus.issue_sel), 64'h0);
        step();
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            step();
            rst                = $urandom_range(0, 149) == 0;
            bus.pipe_flush     = $urandom_range(0, 29) == 0;
            bus.dispatch_valid = 2'($urandom);
            bus.rs_avail       = 16'($urandom) & 16'($urandom);
            for (int e = 0; e < D; e++) begin
                bus.rs_wake_up[e] = bus.rs_avail[e] ? 2'b00 : 2'($urandom);
                bus.rs_age[e]     = 6'($urandom);
            end
            bus.rob_head = 6'($urandom);
            bus.fu_ready = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
        end
        step();
        idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
